// File: rtl/mo_line_buffer_pp.sv
// Ping-pong motion-object line buffer: one bank is written for the next line while the
// other is read out and cleared behind the read pointer. Optional macro: MOLB_PRIORITY_EN.
module mo_line_buffer_pp #(
    parameter int PIX_W       = 8,
    parameter int LINE_W      = 336,
    parameter int XW          = 9,
    parameter int TRANSP_BITS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             line_start,
    input  logic             wr_load,
    input  logic [XW-1:0]    wr_x,
    input  logic             wr_valid,
    input  logic [PIX_W-1:0] wr_pix,
    input  logic             rd_en,
    output logic [PIX_W-1:0] rd_pix,
    output logic             rd_valid,
    output logic             bank,
    input  logic             clr_req,
    output logic             clr_busy,
    output logic             ovf
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [XW:0]      LINE_LEN = (XW+1)'(LINE_W);
    localparam logic [XW-1:0]    LAST_X   = XW'(LINE_W - 1);
    localparam logic [PIX_W-1:0] BLANK    = '1;

    // NOTE: the line RAMs have no reset; contents are don't-care until the first clear.
    logic [PIX_W-1:0] mem_a [LINE_W];
    logic [PIX_W-1:0] mem_b [LINE_W];

    state_t           state, state_next;
    logic [XW-1:0]    cptr, cptr_next;
    logic [XW-1:0]    wptr;
    logic [XW:0]      rptr;

    logic             wr_step, wr_in_range, wr_transp, wr_suppress;
    logic             wb_we;
    logic [XW-1:0]    wb_addr;
    logic [PIX_W-1:0] wb_data;
    logic             rd_fire;
    logic [XW-1:0]    rd_addr;
    logic [PIX_W-1:0] rd_data;

    assign clr_busy    = (state == CLEAR);
    assign wr_step     = wr_valid && !wr_load && !line_start && (state == IDLE);
    assign wr_in_range = ({1'b0, wptr} < LINE_LEN);
    assign wr_transp   = &wr_pix[TRANSP_BITS-1:0];
    assign rd_fire     = rd_en && !line_start && (rptr != LINE_LEN);
    assign rd_addr     = rptr[XW-1:0];
    assign rd_data     = bank ? mem_a[rd_addr] : mem_b[rd_addr];

`ifdef MOLB_PRIORITY_EN
    // First object written at an X keeps it: peek at the write bank before overwriting.
    logic [PIX_W-1:0] wb_cur;
    assign wb_cur      = bank ? mem_b[wptr] : mem_a[wptr];
    assign wr_suppress = ~&wb_cur[TRANSP_BITS-1:0];
`else
    assign wr_suppress = 1'b0;
`endif

    // Write-bank port: bulk clear owns it while busy, otherwise the object shifter.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        wb_we   = 1'b0;
        wb_addr = wptr;
        wb_data = wr_pix;
        if (!line_start) begin
            if (state == CLEAR) begin
                wb_we   = 1'b1;
                wb_addr = cptr;
                wb_data = BLANK;
            end else if (wr_step && wr_in_range && !wr_transp && !wr_suppress) begin
                wb_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (bank == 1'b0) begin
            if (wb_we)   mem_a[wb_addr] <= wb_data;
            if (rd_fire) mem_b[rd_addr] <= BLANK;
        end else begin
            if (wb_we)   mem_b[wb_addr] <= wb_data;
            if (rd_fire) mem_a[rd_addr] <= BLANK;
        end
    end

    always_comb begin
        state_next = state;
        cptr_next  = cptr;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_next = CLEAR;
                    cptr_next  = '0;
                end
            end
            CLEAR: begin
                if (line_start || cptr == LAST_X) state_next = IDLE;
                else                              cptr_next  = cptr + 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cptr  <= '0;
        end else begin
            state <= state_next;
            cptr  <= cptr_next;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            bank     <= 1'b0;
            wptr     <= '0;
            rptr     <= '0;
            ovf      <= 1'b0;
            rd_pix   <= BLANK;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_fire;
            if (rd_fire) rd_pix <= rd_data;
            if (line_start) begin
                bank <= ~bank;
                wptr <= '0;
                rptr <= '0;
                ovf  <= 1'b0;
            end else begin
                if (wr_load && state == IDLE) begin
                    wptr <= wr_x;
                end else if (wr_step) begin
                    wptr <= wptr + 1'b1;
                    if (!wr_in_range) ovf <= 1'b1;
                end
                if (rd_fire) rptr <= rptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mo_line_buffer_pp.sv
// Self-checking bench for mo_line_buffer_pp: directed line sequences, a vector table,
// and randomized traffic against a per-line array model of both banks.
module tb_mo_line_buffer_pp;

    localparam int PIX_W       = 8;
    localparam int LINE_W      = 336;
    localparam int XW          = 9;
    localparam int TRANSP_BITS = 4;
    localparam logic [7:0] FF  = 8'hFF;

    logic             clk = 1'b0;
    logic             reset, line_start, wr_load, wr_valid, rd_en, clr_req;
    logic [XW-1:0]    wr_x;
    logic [PIX_W-1:0] wr_pix, rd_pix;
    logic             rd_valid, bank, clr_busy, ovf;

    always #5 clk = ~clk;

    mo_line_buffer_pp #(
        .PIX_W(PIX_W), .LINE_W(LINE_W), .XW(XW), .TRANSP_BITS(TRANSP_BITS)
    ) dut (
        .clk(clk), .reset(reset), .line_start(line_start), .wr_load(wr_load),
        .wr_x(wr_x), .wr_valid(wr_valid), .wr_pix(wr_pix), .rd_en(rd_en),
        .rd_pix(rd_pix), .rd_valid(rd_valid), .bank(bank), .clr_req(clr_req),
        .clr_busy(clr_busy), .ovf(ovf)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: contents of both banks plus the line-level pointers and flags.
    logic [7:0] m_mem   [2][LINE_W];
    bit         m_known [2][LINE_W];
    int         m_bank, m_wptr, m_rptr, m_cptr;
    bit         m_ovf, m_busy, m_valid, m_pix_known;
    logic [7:0] m_pix;
    logic [7:0] got [LINE_W];

    function automatic bit is_transp(input logic [7:0] p);
        return &p[TRANSP_BITS-1:0];
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int x = 0; x < LINE_W; x++) m_known[b][x] = 1'b0;
        m_bank = 0; m_wptr = 0; m_rptr = 0; m_cptr = 0;
        m_ovf = 0; m_busy = 0; m_valid = 0; m_pix = FF; m_pix_known = 1;
    endtask

    task automatic model_step();
        int wb = m_bank;
        int rb = 1 - m_bank;
        bit was_busy = m_busy;
        m_valid = 0;
        if (line_start) begin
            m_busy = 0;
            m_bank = 1 - m_bank;
            m_wptr = 0; m_rptr = 0; m_ovf = 0;
        end else begin
            if (m_busy) begin
                m_mem[wb][m_cptr] = FF; m_known[wb][m_cptr] = 1;
                if (m_cptr == LINE_W - 1) m_busy = 0;
                else                      m_cptr++;
            end else if (wr_load) begin
                m_wptr = int'(wr_x);
            end else if (wr_valid) begin
                if (m_wptr >= LINE_W) m_ovf = 1;
                else if (!is_transp(wr_pix)) begin
`ifdef MOLB_PRIORITY_EN
                    if (!m_known[wb][m_wptr]) m_known[wb][m_wptr] = 0;
                    else if (is_transp(m_mem[wb][m_wptr])) m_mem[wb][m_wptr] = wr_pix;
`else
                    m_mem[wb][m_wptr] = wr_pix; m_known[wb][m_wptr] = 1;
`endif
                end
                m_wptr = (m_wptr + 1) % (1 << XW);
            end
            if (rd_en && m_rptr < LINE_W) begin
                m_valid = 1;
                m_pix = m_mem[rb][m_rptr]; m_pix_known = m_known[rb][m_rptr];
                m_mem[rb][m_rptr] = FF; m_known[rb][m_rptr] = 1;
                m_rptr++;
            end
        end
        if (!was_busy && clr_req) begin m_busy = 1; m_cptr = 0; end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk); #1;
        check("bank", int'(bank), m_bank);
        check("ovf", int'(ovf), int'(m_ovf));
        check("clr_busy", int'(clr_busy), int'(m_busy));
        check("rd_valid", int'(rd_valid), int'(m_valid));
        if (m_pix_known) check("rd_pix", int'(rd_pix), int'(m_pix));
    endtask

    task automatic set_idle();
        line_start = 0; wr_load = 0; wr_x = '0; wr_valid = 0;
        wr_pix = '0; rd_en = 0; clr_req = 0;
    endtask

    task automatic pulse_line();
        line_start = 1; tick(); line_start = 0;
    endtask

    task automatic write_strip(input int x, input logic [7:0] p);
        wr_load = 1; wr_x = XW'(x); tick(); wr_load = 0;
        wr_valid = 1; wr_pix = p; tick(); wr_valid = 0;
    endtask

    task automatic read_pass(input int n, input bit with_clear, output int nvalid);
        nvalid = 0;
        for (int i = 0; i < LINE_W; i++) got[i] = 8'h00;
        clr_req = with_clear; rd_en = 1;
        for (int i = 0; i < n; i++) begin
            tick(); clr_req = 0;
            if (rd_valid) begin
                if (nvalid < LINE_W) got[nvalid] = rd_pix;
                nvalid++;
            end
        end
        rd_en = 0;
    endtask

    task automatic wait_clear(input int budget);
        for (int i = 0; i < budget && clr_busy; i++) tick();
        check("clear_done", int'(clr_busy), 0);
    endtask

    function automatic int count_not_ff(input int lo, input int hi);
        int n = 0;
        for (int x = 0; x < LINE_W; x++)
            if ((x < lo || x > hi) && got[x] !== FF) n++;
        return n;
    endfunction

    typedef struct {
        logic [7:0] wpix;
        int         addr;
        logic [7:0] exp;
    } vec_t;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t vecs[4];
        int   busy_cnt, nv, prev_bank;
        vecs[0] = '{8'h01, 10, 8'h01};
        vecs[1] = '{8'h0F, 11, 8'hFF};
        vecs[2] = '{8'h23, 12, 8'h23};
        vecs[3] = '{8'h34, 13, 8'h34};

        // Reset
        set_idle();
        reset = 1;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        model_reset();
        check("rst_rd_pix", int'(rd_pix), int'(FF));
        check("rst_rd_valid", int'(rd_valid), 0);
        check("rst_bank", int'(bank), 0);
        check("rst_clr_busy", int'(clr_busy), 0);
        check("rst_ovf", int'(ovf), 0);

        // 1: bulk clear lasts LINE_W cycles; cleared bank reads back all ones
        clr_req = 1; tick(); clr_req = 0;
        busy_cnt = 0;
        for (int i = 0; i < 400 && clr_busy; i++) begin busy_cnt++; tick(); end
        check("t1_busy_cycles", busy_cnt, LINE_W);
        pulse_line();
        read_pass(LINE_W + 1, 1'b1, nv);
        check("t1_valid_reads", nv, LINE_W);
        check("t1_non_ff", count_not_ff(LINE_W, LINE_W), 0);
        check("t1_rd_end", int'(rd_valid), 0);
        wait_clear(20);

        // 2: strip at X=10 with one transparent pixel
        wr_load = 1; wr_x = XW'(10); tick(); wr_load = 0;
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1; wr_pix = vecs[i].wpix; tick();
        end
        wr_valid = 0;
        pulse_line();
        read_pass(LINE_W, 1'b0, nv);
        for (int i = 0; i < 4; i++)
            check($sformatf("t2_addr%0d", vecs[i].addr), int'(got[vecs[i].addr]), int'(vecs[i].exp));
        check("t2_others_ff", count_not_ff(10, 13), 0);
        pulse_line();
        pulse_line();
        read_pass(LINE_W, 1'b0, nv);
        check("t2_cleared_behind", count_not_ff(LINE_W, LINE_W), 0);

        // 3: strip running off the end of the line
        wr_load = 1; wr_x = XW'(334); tick(); wr_load = 0;
        wr_valid = 1; wr_pix = 8'h11;
        repeat (4) tick();
        wr_valid = 0;
        check("t3_ovf_set", int'(ovf), 1);
        pulse_line();
        check("t3_ovf_clr", int'(ovf), 0);
        read_pass(LINE_W, 1'b0, nv);
        check("t3_addr333", int'(got[333]), int'(FF));
        check("t3_addr334", int'(got[334]), 8'h11);
        check("t3_addr335", int'(got[335]), 8'h11);

        // 4: line_start wins over a simultaneous write and read
        prev_bank = int'(bank);
        line_start = 1; wr_valid = 1; wr_pix = 8'h77; rd_en = 1;
        tick();
        set_idle();
        check("t4_bank_toggle", int'(bank), 1 - prev_bank);
        check("t4_rd_valid", int'(rd_valid), 0);
        read_pass(LINE_W + 1, 1'b0, nv);
        check("t4_rptr_zero", nv, LINE_W);
        check("t4_no_write", int'(got[0]), int'(FF));

        // 5: bulk clear aborted by line_start leaves the other bank alone
        write_strip(50, 8'h55);
        pulse_line();
        clr_req = 1; tick(); clr_req = 0;
        repeat (99) tick();
        check("t5_busy_mid", int'(clr_busy), 1);
        prev_bank = int'(bank);
        pulse_line();
        check("t5_busy_drop", int'(clr_busy), 0);
        check("t5_bank_toggle", int'(bank), 1 - prev_bank);
        pulse_line();
        read_pass(LINE_W, 1'b0, nv);
        check("t5_kept", int'(got[50]), 8'h55);

        // 6: two objects on the same X in one line
        clr_req = 1; tick(); clr_req = 0;
        wait_clear(400);
        write_strip(5, 8'h21);
        write_strip(5, 8'h42);
        pulse_line();
        read_pass(LINE_W, 1'b0, nv);
`ifdef MOLB_PRIORITY_EN
        check("t6_overlap", int'(got[5]), 8'h21);
`else
        check("t6_overlap", int'(got[5]), 8'h42);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            line_start = ($urandom_range(0, 399) == 0);
            clr_req    = ($urandom_range(0, 299) == 0);
            wr_load    = ($urandom_range(0, 19) == 0);
            wr_x       = ($urandom_range(0, 1) == 0) ? XW'($urandom_range(300, 400))
                                                     : XW'($urandom_range(0, 511));
            wr_valid   = ($urandom_range(0, 1) == 1);
            wr_pix     = ($urandom_range(0, 3) == 0) ? 8'h0F : PIX_W'($urandom);
            rd_en      = ($urandom_range(0, 2) != 0);
            tick();
        end
        set_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
